// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
//   Shared raster timing defaults for the 640x480@60 Hz display pipeline and
//   the screen-coordinate type used by vga_timing_gen, color_mapper and the
//   sprite/ball modules.
//
//   Contents:
//     H_VISIBLE..H_BP, V_VISIBLE..V_BP  default porch/sync/visible sizes
//     H_TOTAL, V_TOTAL                  derived line/frame lengths
//     coord_t                           10-bit unsigned screen coordinate
//     in_window()                       half-open range test on coordinates
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;

  // True when lo <= v < hi.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
//   Enable-gated shift register used to hold sync/blank back so they line up
//   with downstream registered pixel data.
//
//   Parameters:
//     DEPTH  number of stages; 0 gives a single free-running register
//     WIDTH  bits per stage
//   Ports:
//     i_clk      clock
//     i_rst_n    asynchronous active-low reset
//     i_en       shift enable (ignored when DEPTH == 0)
//     i_rst_val  value loaded into every stage during reset
//     i_d        data into the first stage
//     o_q        last stage
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_rst_val,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic [WIDTH-1:0] r_q;
      logic             w_unused_en;

      // With no delay requested the input is still registered once per clock.
      assign w_unused_en = i_en;

      // Single output register, loads every cycle.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_q <= i_rst_val;
        end else begin
          r_q <= i_d;
        end
      end

      assign o_q = r_q;
    end else begin : g_shift
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift chain, advancing only on enabled cycles.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= i_rst_val;
          end
        end else if (i_en) begin
          r_stage[0] <= i_d;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i];
          end
        end
      end

      assign o_q = r_stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
//   Raster timing generator feeding color_mapper. Divides Clk down to the
//   pixel rate, walks DrawX/DrawY over the full line/frame (including
//   porches and sync), and produces VGA sync/blank delayed by SYNC_DELAY
//   pixel ticks so they stay aligned with color_mapper's registered RGB.
//
//   Optional feature macro: VGA_FRAME_COUNT_EN adds the frame_count port.
//
//   Ports:
//     Clk          system clock (50 MHz)
//     Reset        asynchronous active-low reset
//     pixel_en     one-Clk pulse per pixel tick
//     DrawX/DrawY  current raster position (0..H_TOTAL-1 / 0..V_TOTAL-1)
//     VGA_CLK      registered pixel clock for the DAC
//     VGA_HS/VS    active-low syncs, delayed
//     VGA_BLANK_N  high in the visible region, delayed
//     VGA_SYNC_N   tied low
//     line_start   one-Clk pulse in the first cycle with DrawX == 0
//     frame_start  one-Clk pulse in the first cycle with (DrawX,DrawY) == (0,0)
//     frame_count  frames since reset, wraps at 255 (VGA_FRAME_COUNT_EN only)
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FP       = vga_pkg::H_FP,
  parameter int unsigned H_SYNC     = vga_pkg::H_SYNC,
  parameter int unsigned H_BP       = vga_pkg::H_BP,
  parameter int unsigned V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FP       = vga_pkg::V_FP,
  parameter int unsigned V_SYNC     = vga_pkg::V_SYNC,
  parameter int unsigned V_BP       = vga_pkg::V_BP,
  parameter int unsigned PIX_DIV    = 2,
  parameter int          SYNC_DELAY = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       pixel_en,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       line_start,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_count
`endif
);

  localparam int unsigned LOC_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned LOC_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t C_H_LAST   = coord_t'(LOC_H_TOTAL - 1);
  localparam coord_t C_V_LAST   = coord_t'(LOC_V_TOTAL - 1);
  localparam coord_t C_H_VIS    = coord_t'(H_VISIBLE);
  localparam coord_t C_V_VIS    = coord_t'(V_VISIBLE);
  localparam coord_t C_HS_START = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t C_HS_END   = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t C_VS_START = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t C_VS_END   = coord_t'(V_VISIBLE + V_FP + V_SYNC);
  localparam coord_t C_ONE      = 10'd1;

  localparam int               DIV_W      = $clog2(PIX_DIV);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_HALF = DIV_W'(PIX_DIV / 2);
  localparam logic [DIV_W-1:0] C_DIV_ONE  = DIV_W'(1);

  // Inactive sync/blank: HS=1, VS=1, BLANK_N=0.
  localparam logic [2:0] C_SYNC_IDLE = 3'b110;

  logic [DIV_W-1:0] r_div;
  logic             r_pix_en;
  logic             r_vga_clk;
  coord_t           r_x;
  coord_t           r_y;
  logic             r_line_start;
  logic             r_frame_start;

  logic             w_hs_raw;
  logic             w_vs_raw;
  logic             w_blank_raw_n;
  logic [2:0]       w_sync_q;

  // Pixel divider. pixel_en and VGA_CLK are registered images of the divider,
  // so the first pixel_en lands PIX_DIV cycles after reset release and the
  // DAC clock rises half a pixel after DrawX/DrawY change.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_div     <= '0;
      r_pix_en  <= 1'b0;
      r_vga_clk <= 1'b0;
    end else begin
      if (r_div == C_DIV_LAST) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + C_DIV_ONE;
      end
      r_pix_en  <= (r_div == C_DIV_LAST);
      r_vga_clk <= (r_div >= C_DIV_HALF);
    end
  end

  // Raster counters plus the wrap strobes, which fire in the first cycle the
  // wrapped coordinate is visible.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      if (r_pix_en) begin
        if (r_x == C_H_LAST) begin
          r_x          <= 10'd0;
          r_line_start <= 1'b1;
          if (r_y == C_V_LAST) begin
            r_y           <= 10'd0;
            r_frame_start <= 1'b1;
          end else begin
            r_y <= r_y + C_ONE;
          end
        end else begin
          r_x <= r_x + C_ONE;
        end
      end else begin
        r_x <= r_x;
        r_y <= r_y;
      end
    end
  end

  // Undelayed sync/blank for the current raster position.
  always_comb begin
    w_hs_raw      = !in_window(r_x, C_HS_START, C_HS_END);
    w_vs_raw      = !in_window(r_y, C_VS_START, C_VS_END);
    w_blank_raw_n = (r_x < C_H_VIS) && (r_y < C_V_VIS);
  end

  // Sync/blank follow their pixel by SYNC_DELAY ticks to match color_mapper.
  vga_delay_line #(
    .DEPTH (SYNC_DELAY),
    .WIDTH (3)
  ) u_sync_delay (
    .i_clk     (Clk),
    .i_rst_n   (Reset),
    .i_en      (r_pix_en),
    .i_rst_val (C_SYNC_IDLE),
    .i_d       ({w_hs_raw, w_vs_raw, w_blank_raw_n}),
    .o_q       (w_sync_q)
  );

`ifdef VGA_FRAME_COUNT_EN
  logic [7:0] r_frame_count;

  // Frame counter for animation; advances once per frame_start and wraps.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_frame_count <= 8'd0;
    end else if (r_frame_start) begin
      r_frame_count <= r_frame_count + 8'd1;
    end else begin
      r_frame_count <= r_frame_count;
    end
  end

  assign frame_count = r_frame_count;
`endif

  assign pixel_en    = r_pix_en;
  assign DrawX       = r_x;
  assign DrawY       = r_y;
  assign VGA_CLK     = r_vga_clk;
  assign VGA_HS      = w_sync_q[2];
  assign VGA_VS      = w_sync_q[1];
  assign VGA_BLANK_N = w_sync_q[0];
  assign VGA_SYNC_N  = 1'b0;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // DUT A uses the full 640x480 timing; DUT B a tiny raster so whole frames fit.
  localparam int AHV = 640, AHF = 16, AHS = 96, AHB = 48;
  localparam int AVV = 480, AVF = 10, AVS = 2,  AVB = 33;
  localparam int BHV = 16,  BHF = 4,  BHS = 6,  BHB = 6;
  localparam int BVV = 10,  BVF = 2,  BVS = 2,  BVB = 3;
  localparam int P   = 2;
  localparam int D   = 2;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       pe;
    logic       vclk;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  int         t;
  int         checks;
  int         errors;

  logic       a_pe, a_vclk, a_hs, a_vs, a_bl, a_sync_n, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_pe, b_vclk, b_hs, b_vs, b_bl, b_sync_n, b_ls, b_fs;
  logic [9:0] b_x, b_y;
  logic [7:0] a_fc, b_fc;

  vga_timing_gen u_dut_a (
    .Clk         (clk),
    .Reset       (rst_n),
    .pixel_en    (a_pe),
    .DrawX       (a_x),
    .DrawY       (a_y),
    .VGA_CLK     (a_vclk),
    .VGA_HS      (a_hs),
    .VGA_VS      (a_vs),
    .VGA_BLANK_N (a_bl),
    .VGA_SYNC_N  (a_sync_n),
    .line_start  (a_ls),
    .frame_start (a_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (a_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE (BHV), .H_FP (BHF), .H_SYNC (BHS), .H_BP (BHB),
    .V_VISIBLE (BVV), .V_FP (BVF), .V_SYNC (BVS), .V_BP (BVB)
  ) u_dut_b (
    .Clk         (clk),
    .Reset       (rst_n),
    .pixel_en    (b_pe),
    .DrawX       (b_x),
    .DrawY       (b_y),
    .VGA_CLK     (b_vclk),
    .VGA_HS      (b_hs),
    .VGA_VS      (b_vs),
    .VGA_BLANK_N (b_bl),
    .VGA_SYNC_N  (b_sync_n),
    .line_start  (b_ls),
    .frame_start (b_fs)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_count (b_fc)
`endif
  );

`ifndef VGA_FRAME_COUNT_EN
  assign a_fc = 8'd0;
  assign b_fc = 8'd0;
`endif

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Clk edges since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  // Expected outputs in the cycle after t edges since reset release, from the
  // raster rules: pixel n is shown in the cycles following n pixel ticks, and
  // sync/blank lag their pixel by D ticks.
  function automatic exp_t model(input int tt, input int hv, input int hf, input int hsw, input int hb,
                                 input int vv, input int vf, input int vsw, input int vb);
    exp_t e;
    int ht, vt, n, np, m, x, y;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (tt >= 1) begin
      n  = (tt - 1) / P;
      np = (tt >= 2) ? (tt - 2) / P : 0;
      e.x    = 10'(n % ht);
      e.y    = 10'((n / ht) % vt);
      e.pe   = ((tt - 1) % P) == P - 1;
      e.vclk = ((tt - 1) % P) >= P / 2;
      e.ls   = (n != np) && (n % ht == 0);
      e.fs   = (n != np) && (n % (ht * vt) == 0);
      if (n >= D) begin
        m = n - D;
        x = m % ht;
        y = (m / ht) % vt;
        e.hs = !((x >= hv + hf) && (x < hv + hf + hsw));
        e.vs = !((y >= vv + vf) && (y < vv + vf + vsw));
        e.bl = (x < hv) && (y < vv);
      end
      if (tt >= 2) e.fc = 8'(((tt - 2) / (ht * vt * P)) % 256);
    end
    return e;
  endfunction

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if ({a_pe, a_x, a_y, a_vclk, a_hs, a_vs, a_bl, a_ls, a_fs, a_sync_n, a_fc} !==
        {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL reset_state: pe=%b x=%0d y=%0d vclk=%b hs=%b vs=%b bl=%b ls=%b fs=%b sync_n=%b fc=%0d, required 0 0 0 0 1 1 0 0 0 0 0",
               a_pe, a_x, a_y, a_vclk, a_hs, a_vs, a_bl, a_ls, a_fs, a_sync_n, a_fc);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_pe !== 1'b0 || a_x !== 10'd0) begin
      errors++;
      $display("FAIL first_cycle: pe=%b x=%0d, required pe=0 x=0", a_pe, a_x);
    end
    @(negedge clk);
    checks++;
    if (a_pe !== 1'b1 || a_x !== 10'd0) begin
      errors++;
      $display("FAIL first_pixel_en: pe=%b x=%0d at cycle 2, required pe=1 x=0", a_pe, a_x);
    end
    @(negedge clk);
    checks++;
    if (a_pe !== 1'b0 || a_x !== 10'd1 || a_bl !== 1'b0) begin
      errors++;
      $display("FAIL after_first_tick: pe=%b x=%0d bl=%b, required pe=0 x=1 bl=0", a_pe, a_x, a_bl);
    end
  endtask

  task automatic test_cadence();
    logic exp_pe;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      exp_pe = (t >= 2) && (t % 2 == 0);
      checks++;
      if (a_pe !== exp_pe || a_vclk !== exp_pe) begin
        errors++;
        $display("FAIL cadence t=%0d: pe=%b vclk=%b, required %b %b", t, a_pe, a_vclk, exp_pe, exp_pe);
      end
    end
  endtask

  task automatic test_line_wrap();
    int guard;
    do_reset(3);
    guard = 0;
    while (!(a_x == 10'd799 && a_y == 10'd10) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    guard = 0;
    while (a_pe !== 1'b1 && guard < 4) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (a_x !== 10'd799 || a_y !== 10'd10 || a_pe !== 1'b1) begin
      errors++;
      $display("FAIL line_wrap_reach: x=%0d y=%0d pe=%b, required 799 10 1", a_x, a_y, a_pe);
    end
    @(negedge clk);
    checks++;
    if (a_x !== 10'd0 || a_y !== 10'd11 || a_ls !== 1'b1 || a_fs !== 1'b0) begin
      errors++;
      $display("FAIL line_wrap: x=%0d y=%0d ls=%b fs=%b, required 0 11 1 0", a_x, a_y, a_ls, a_fs);
    end
    @(negedge clk);
    checks++;
    if (a_ls !== 1'b0) begin
      errors++;
      $display("FAIL line_start_width: ls=%b one cycle later, required 0", a_ls);
    end
  endtask

  task automatic test_hs_timing();
    int pk, k640, k656, hs_fall, hs_rise, bl_fall;
    logic hs_prev, bl_prev;
    do_reset(2);
    pk = 0; k640 = -1; k656 = -1; hs_fall = -1; hs_rise = -1; bl_fall = -1;
    hs_prev = 1'b1; bl_prev = 1'b0;
    for (int k = 0; k < 3000 && hs_rise < 0; k++) begin
      @(negedge clk);
      if (a_x == 10'd640 && k640 < 0) k640 = pk;
      if (a_x == 10'd656 && k656 < 0) k656 = pk;
      if (hs_prev && !a_hs && hs_fall < 0) hs_fall = pk;
      if (!hs_prev && a_hs && hs_fall >= 0) hs_rise = pk;
      if (bl_prev && !a_bl && bl_fall < 0) bl_fall = pk;
      hs_prev = a_hs;
      bl_prev = a_bl;
      if (a_pe) pk++;
    end
    checks++;
    if (hs_rise < 0 || k656 < 0 || hs_fall - k656 != 2) begin
      errors++;
      $display("FAIL hs_start: HS fell %0d ticks after DrawX=656, required 2", hs_fall - k656);
    end
    checks++;
    if (hs_rise < 0 || hs_rise - hs_fall != 96) begin
      errors++;
      $display("FAIL hs_width: %0d ticks, required 96", hs_rise - hs_fall);
    end
    checks++;
    if (k640 < 0 || bl_fall < 0 || bl_fall - k640 != 2) begin
      errors++;
      $display("FAIL blank_fall: BLANK_N fell %0d ticks after DrawX=640, required 2", bl_fall - k640);
    end
  endtask

  task automatic test_frame();
    int pk, t1, t2, k_vs, vs_fall, vs_rise;
    logic vs_prev;
    do_reset(2);
    pk = 0; t1 = -1; t2 = -1; k_vs = -1; vs_fall = -1; vs_rise = -1; vs_prev = 1'b1;
    for (int k = 0; k < 5000 && t2 < 0; k++) begin
      @(negedge clk);
      if (b_x == 10'd0 && b_y == 10'(BVV + BVF) && k_vs < 0) k_vs = pk;
      if (vs_prev && !b_vs && vs_fall < 0) vs_fall = pk;
      if (!vs_prev && b_vs && vs_fall >= 0 && vs_rise < 0) vs_rise = pk;
      vs_prev = b_vs;
      if (b_fs) begin
        checks++;
        if (b_ls !== 1'b1 || b_x !== 10'd0 || b_y !== 10'd0) begin
          errors++;
          $display("FAIL frame_start_coincide: ls=%b x=%0d y=%0d, required 1 0 0", b_ls, b_x, b_y);
        end
        if (t1 < 0) t1 = t;
        else begin
          t2 = t;
`ifdef VGA_FRAME_COUNT_EN
          checks++;
          if (b_fc !== 8'd1) begin
            errors++;
            $display("FAIL frame_count: %0d at second frame_start, required 1", b_fc);
          end
`endif
        end
      end
      if (b_pe) pk++;
    end
    checks++;
    if (t1 != (BHV+BHF+BHS+BHB) * (BVV+BVF+BVS+BVB) * P + 1) begin
      errors++;
      $display("FAIL first_frame_start: at cycle %0d, required %0d", t1, (BHV+BHF+BHS+BHB) * (BVV+BVF+BVS+BVB) * P + 1);
    end
    checks++;
    if (t2 < 0 || t2 - t1 != (BHV+BHF+BHS+BHB) * (BVV+BVF+BVS+BVB) * P) begin
      errors++;
      $display("FAIL frame_period: %0d Clk, required %0d", t2 - t1, (BHV+BHF+BHS+BHB) * (BVV+BVF+BVS+BVB) * P);
    end
    checks++;
    if (k_vs < 0 || vs_fall - k_vs != 2 || vs_rise - vs_fall != BVS * (BHV+BHF+BHS+BHB)) begin
      errors++;
      $display("FAIL vs_timing: start offset %0d width %0d ticks, required 2 and %0d",
               vs_fall - k_vs, vs_rise - vs_fall, BVS * (BHV+BHF+BHS+BHB));
    end
  endtask

  task automatic test_mid_reset();
    int guard;
    do_reset(2);
    guard = 0;
    while (a_x != 10'd700 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (a_x !== 10'd700 || a_hs !== 1'b0) begin
      errors++;
      $display("FAIL mid_hs_reach: x=%0d hs=%b, required 700 0", a_x, a_hs);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_pe, a_x, a_y, a_vclk, a_hs, a_vs, a_bl, a_ls, a_fs, a_fc} !==
        {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL async_reset: pe=%b x=%0d y=%0d vclk=%b hs=%b vs=%b bl=%b ls=%b fs=%b fc=%0d, required 0 0 0 0 1 1 0 0 0 0",
               a_pe, a_x, a_y, a_vclk, a_hs, a_vs, a_bl, a_ls, a_fs, a_fc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    exp_t ea, eb, oa, ob;
    int   len;
    for (int it = 0; it < 8; it++) begin
      do_reset($urandom_range(1, 6));
      len = $urandom_range(300, 2500);
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        ea = model(t, AHV, AHF, AHS, AHB, AVV, AVF, AVS, AVB);
        eb = model(t, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB);
        oa = {a_x, a_y, a_hs, a_vs, a_bl, a_pe, a_vclk, a_ls, a_fs, a_fc};
        ob = {b_x, b_y, b_hs, b_vs, b_bl, b_pe, b_vclk, b_ls, b_fs, b_fc};
`ifndef VGA_FRAME_COUNT_EN
        ea.fc = 8'd0;
        eb.fc = 8'd0;
`endif
        checks++;
        if (oa !== ea) begin
          errors++;
          $display("FAIL rand_full t=%0d: got %h expected %h (x,y,hs,vs,bl,pe,vclk,ls,fs,fc)", t, oa, ea);
        end
        checks++;
        if (ob !== eb) begin
          errors++;
          $display("FAIL rand_small t=%0d: got %h expected %h (x,y,hs,vs,bl,pe,vclk,ls,fs,fc)", t, ob, eb);
        end
      end
      checks++;
      if (a_sync_n !== 1'b0 || b_sync_n !== 1'b0) begin
        errors++;
        $display("FAIL sync_n: %b %b, required 0 0", a_sync_n, b_sync_n);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    test_reset();
    test_cadence();
    test_line_wrap();
    test_hs_timing();
    test_frame();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
